vga_timing_ctr: RTL and testbench

Pixel-clock VGA timing generator and output stage for the 640x480@60 display path. Counts horizontal and vertical position and raises a per-pixel read enable to the BRAM port-B read controller across a MAX_COL x MAX_ROW image window. It takes back that controller's 8-bit grayscale pixel and its valid flag two cycles later and drives the RGB444 DAC pins with matched, re-aligned hsync and vsync. It also flags any pixel/enable misalignment.

---
 rtl/vga_timing_ctr.sv | 103 ++++++++++
 tb/tb_vga_timing_ctr.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctr.sv
// vga_timing_ctr: 640x480@60 timing, BRAM read enable and RGB444 output stage (border via VGA_BORDER_EN).
module vga_timing_ctr #(
  parameter int MAX_ROW = 360,
  parameter int MAX_COL = 540,
  parameter int IMG_X   = 50,
  parameter int IMG_Y   = 60,
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       bram_en_o,
  input  logic [7:0] RGB_i,
  input  logic       RGB_en_i,
  output logic [3:0] vga_r_o,
  output logic [3:0] vga_g_o,
  output logic [3:0] vga_b_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       frame_o,
  output logic       sync_err_o
);
  localparam logic [9:0] H_LAST = 10'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HA = 10'(H_ACT);
  localparam logic [9:0] VA = 10'(V_ACT);
  localparam logic [9:0] HS0 = 10'(H_ACT + H_FP);
  localparam logic [9:0] HS1 = 10'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0] VS0 = 10'(V_ACT + V_FP);
  localparam logic [9:0] VS1 = 10'(V_ACT + V_FP + V_SYNC);
  localparam logic [9:0] X0 = 10'(IMG_X);
  localparam logic [9:0] X1 = 10'(IMG_X + MAX_COL);
  localparam logic [9:0] Y0 = 10'(IMG_Y);
  localparam logic [9:0] Y1 = 10'(IMG_Y + MAX_ROW);
  typedef struct packed {
    logic frm;
    logic brd;
    logic img;
    logic act;
    logic vs;
    logic hs;
  } pipe_t;
  logic [9:0] h_cnt, v_cnt;
  logic       brd, err_q, err_nx;
  logic [3:0] col;
  pipe_t      p0, p1, p2;
  logic       unused;
  assign unused = ^RGB_i[3:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 10'd1;
      if (h_cnt == H_LAST) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end
  assign bram_en_o = h_cnt >= X0 && h_cnt < X1 && v_cnt >= Y0 && v_cnt < Y1;
`ifdef VGA_BORDER_EN
  assign brd = h_cnt < HA && v_cnt < VA &&
               (((h_cnt == X0 - 10'd1 || h_cnt == X1) && v_cnt >= Y0 - 10'd1 && v_cnt <= Y1) ||
                ((v_cnt == Y0 - 10'd1 || v_cnt == Y1) && h_cnt >= X0 - 10'd1 && h_cnt <= X1));
`else
  assign brd = 1'b0;
`endif
  // syncs travel active-high so cleared pipeline registers mean "not in sync"
  always_comb begin
    p0.frm = h_cnt == '0 && v_cnt == '0;
    p0.brd = brd;
    p0.img = bram_en_o;
    p0.act = h_cnt < HA && v_cnt < VA;
    p0.vs  = v_cnt >= VS0 && v_cnt < VS1;
    p0.hs  = h_cnt >= HS0 && h_cnt < HS1;
  end
  assign err_nx     = err_q | (RGB_en_i != p2.img);
  assign sync_err_o = rst_n & err_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p1      <= '0;
      p2      <= '0;
      err_q   <= 1'b0;
      col     <= '0;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      p1      <= p0;
      p2      <= p1;
      err_q   <= err_nx;
      col     <= (p2.act && !err_nx) ? (RGB_en_i ? RGB_i[7:4] : {4{p2.brd}}) : 4'h0;
      hsync_o <= !p2.hs;
      vsync_o <= !p2.vs;
      frame_o <= p2.frm;
    end
  assign vga_r_o = col;
  assign vga_g_o = col;
  assign vga_b_o = col;
endmodule

// File: tb/tb_vga_timing_ctr.sv
// tb_vga_timing_ctr: full-size and scaled-down instances checked every cycle against a timing/pixel model.
module tb_vga_timing_ctr;
`ifdef VGA_BORDER_EN
  localparam bit BRD = 1'b1;
`else
  localparam bit BRD = 1'b0;
`endif
  localparam int HA [2] = '{640, 64};
  localparam int HF [2] = '{16, 4};
  localparam int HS [2] = '{96, 8};
  localparam int HB [2] = '{48, 4};
  localparam int VA [2] = '{480, 48};
  localparam int VF [2] = '{10, 2};
  localparam int VS [2] = '{2, 2};
  localparam int VB [2] = '{33, 4};
  localparam int MC [2] = '{540, 40};
  localparam int MR [2] = '{360, 30};
  localparam int IX [2] = '{50, 5};
  localparam int IY [2] = '{60, 6};
  localparam int HT1 = 80;
  localparam int FT1 = 80 * 56;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  bit          dly = 1'b0;
  logic [31:0] seed = 32'h0;
  logic [1:0]  en, rgb_en, hs, vs, frm, err;
  logic [7:0]  rgb [2];
  logic [3:0]  r [2], g [2], b [2];
  logic [2:0]  en_d [2];
  int          addr [2];
  int          t = 0, errors = 0, checks = 0, fcnt = 0;
  always #20 clk = ~clk;
  function automatic logic [7:0] pix(int a, logic [31:0] s);
    logic [31:0] x;
    x = 32'(a) * 32'h9E3779B1 + s;
    return x[23:16];
  endfunction
  assign rgb[0]    = pix(addr[0], seed);
  assign rgb[1]    = pix(addr[1], seed);
  assign rgb_en[0] = en_d[0][1];
  assign rgb_en[1] = dly ? en_d[1][2] : en_d[1][1];
  // read controller model: returns the pixel two (or three) cycles after the request
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      en_d[0] <= '0;
      en_d[1] <= '0;
      addr[0] <= 0;
      addr[1] <= 0;
    end else
      for (int i = 0; i < 2; i++) begin
        en_d[i] <= {en_d[i][1:0], en[i]};
        if (rgb_en[i]) addr[i] <= (addr[i] == MC[i] * MR[i] - 1) ? 0 : addr[i] + 1;
      end
  vga_timing_ctr dut_full (
    .clk(clk), .rst_n(rst_n), .bram_en_o(en[0]), .RGB_i(rgb[0]), .RGB_en_i(rgb_en[0]),
    .vga_r_o(r[0]), .vga_g_o(g[0]), .vga_b_o(b[0]), .hsync_o(hs[0]), .vsync_o(vs[0]),
    .frame_o(frm[0]), .sync_err_o(err[0])
  );
  vga_timing_ctr #(
    .MAX_ROW(30), .MAX_COL(40), .IMG_X(5), .IMG_Y(6),
    .H_ACT(64), .H_FP(4), .H_SYNC(8), .H_BP(4), .V_ACT(48), .V_FP(2), .V_SYNC(2), .V_BP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bram_en_o(en[1]), .RGB_i(rgb[1]), .RGB_en_i(rgb_en[1]),
    .vga_r_o(r[1]), .vga_g_o(g[1]), .vga_b_o(b[1]), .hsync_o(hs[1]), .vsync_o(vs[1]),
    .frame_o(frm[1]), .sync_err_o(err[1])
  );
  function automatic int ht(int i);
    return HA[i] + HF[i] + HS[i] + HB[i];
  endfunction
  function automatic int vt(int i);
    return VA[i] + VF[i] + VS[i] + VB[i];
  endfunction
  function automatic bit in_img(int i, int s);
    int h, v;
    h = s % ht(i);
    v = (s / ht(i)) % vt(i);
    return h >= IX[i] && h < IX[i] + MC[i] && v >= IY[i] && v < IY[i] + MR[i];
  endfunction
  function automatic bit in_brd(int i, int h, int v);
    return BRD && (((h == IX[i] - 1 || h == IX[i] + MC[i]) && v >= IY[i] - 1 && v <= IY[i] + MR[i]) ||
                   ((v == IY[i] - 1 || v == IY[i] + MR[i]) && h >= IX[i] - 1 && h <= IX[i] + MC[i]));
  endfunction
  task automatic ck(string tag, int i, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[%0d] t=%0d got %0h expected %0h", tag, i, t, got, exp);
    end
  endtask
  task automatic chk(int i);
    bit dl;
    int t0, s, h, v;
    logic eh, ev, ef;
    logic [3:0] ec;
    logic [7:0] p;
    dl = (i == 1) && dly;
    t0 = IY[i] * ht(i) + IX[i] + 2;
    eh = 1'b1; ev = 1'b1; ef = 1'b0; ec = 4'h0;
    if (t >= 3) begin
      s = t - 3;
      h = s % ht(i);
      v = (s / ht(i)) % vt(i);
      eh = !(h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HS[i]);
      ev = !(v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VS[i]);
      ef = h == 0 && v == 0;
      p = pix((v - IY[i]) * MC[i] + (h - IX[i]), seed);
      if (h < HA[i] && v < VA[i] && !(dl && t >= t0 + 1))
        ec = in_img(i, s) ? p[7:4] : (in_brd(i, h, v) ? 4'hF : 4'h0);
    end
    ck("bram_en", i, 32'(en[i]), 32'(in_img(i, t)));
    ck("hsync", i, 32'(hs[i]), 32'(eh));
    ck("vsync", i, 32'(vs[i]), 32'(ev));
    ck("frame", i, 32'(frm[i]), 32'(ef));
    ck("rgb", i, {20'h0, r[i], g[i], b[i]}, {20'h0, ec, ec, ec});
    ck("sync_err", i, 32'(err[i]), 32'(dl && t >= t0));
  endtask
  task automatic rchk();
    for (int i = 0; i < 2; i++) begin
      ck("rst_bram_en", i, 32'(en[i]), 0);
      ck("rst_sync", i, {30'h0, hs[i], vs[i]}, 32'h3);
      ck("rst_rgb", i, {20'h0, r[i], g[i], b[i]}, 0);
      ck("rst_frame_err", i, {30'h0, frm[i], err[i]}, 0);
    end
  endtask
  task automatic run(int n);
    for (int k = 0; k < n; k++) begin
      chk(0);
      chk(1);
      if (en[1]) fcnt++;
      if (t % FT1 == FT1 - 1) begin
        ck("frame_en_count", 1, fcnt, MC[1] * MR[1]);
        fcnt = 0;
      end
      @(negedge clk);
      t++;
    end
  endtask
  initial begin
    seed = $urandom;
    repeat (3) @(negedge clk);
    rchk();
    rst_n = 1'b1;
    t = 0; fcnt = 0;
    run(49000);
    rst_n = 1'b0;
    #1 rchk();
    @(negedge clk);
    dly = 1'b1;
    rst_n = 1'b1;
    t = 0; fcnt = 0;
    run(FT1 + 10);
    rst_n = 1'b0;
    @(negedge clk);
    dly = 1'b0;
    rst_n = 1'b1;
    t = 0; fcnt = 0;
    run(20 * HT1 + int'($urandom_range(0, HT1 - 1)));
    rst_n = 1'b0;
    #1 rchk();
    @(negedge clk);
    rst_n = 1'b1;
    t = 0; fcnt = 0;
    run(2 * FT1 + 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
